// File: rtl/layer_sched_ctrl.sv
// Read-side schedule sequencer for the layered LDPC SISO row unit.
// Walks layers and addresses, inserts layer gaps, counts iterations, drains.
module layer_sched_ctrl #(
  parameter int ADDRWIDTH = 5,
  parameter int ADDRDEPTH = 20,
  parameter int LAYERS    = 2,
  parameter int GAPCYC    = 13,
  parameter int DRAINCYC  = 13,
  parameter int ITERBITS  = 5,
  parameter int MAXITER   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 early_stop,
  output logic                 rdlayer_regin,
  output logic [ADDRWIDTH-1:0] rdaddress_regin,
  output logic                 rden_LLR_regin,
  output logic                 rden_E,
  output logic                 busy,
  output logic                 done,
  output logic [ITERBITS-1:0]  iter_count
);

  localparam int GW = (GAPCYC > 1) ? $clog2(GAPCYC) : 1;
  localparam int DW = (DRAINCYC > 1) ? $clog2(DRAINCYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  layer_q, layer_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [ITERBITS-1:0]   iter_q, iter_d;
  logic                  stop_q, stop_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;

  logic                  rdlayer_q, rdlayer_d;
  logic [ADDRWIDTH-1:0]  rdaddr_q, rdaddr_d;
  logic [ITERBITS-1:0]   iterout_q, iterout_d;
  logic                  rden_q, rden_d;
  logic                  rdene_q, rdene_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic last_addr, last_layer, stop_now, issue_d;

  assign last_addr  = addr_q == ADDRWIDTH'(ADDRDEPTH - 1);
  assign last_layer = layer_q == 1'(LAYERS - 1);
  assign stop_now   = (iter_q == ITERBITS'(MAXITER - 1))
                    || stop_q || early_stop;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    addr_d  = addr_q;
    iter_d  = iter_q;
    stop_d  = stop_q;
    gcnt_d  = gcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          layer_d = 1'b0;
          addr_d  = '0;
          iter_d  = '0;
          stop_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        stop_d = stop_q | early_stop;
        if (!last_addr) begin
          addr_d = addr_q + 1'b1;
        end else begin
          addr_d = '0;
          if (!last_layer || !stop_now) begin
            if (last_layer) begin
              layer_d = 1'b0;
              iter_d  = iter_q + 1'b1;
            end else begin
              layer_d = layer_q + 1'b1;
            end
            // zero gap keeps the stream contiguous across layers
            if (GAPCYC > 0) begin
              state_d = S_GAP;
              gcnt_d  = GW'(GAPCYC > 0 ? GAPCYC - 1 : 0);
            end
          end else if (DRAINCYC > 0) begin
            state_d = S_DRAIN;
            dcnt_d  = DW'(DRAINCYC > 0 ? DRAINCYC - 1 : 0);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        stop_d = stop_q | early_stop;
        if (gcnt_q == '0) state_d = S_ISSUE;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      S_DRAIN: begin
        stop_d = stop_q | early_stop;
        if (dcnt_q == '0) state_d = S_DONE;
        else              dcnt_d  = dcnt_q - 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_d   = state_d == S_ISSUE;
    rden_d    = issue_d;
    rdene_d   = issue_d && (iter_d != '0);
    busy_d    = (state_d == S_ISSUE) || (state_d == S_GAP)
             || (state_d == S_DRAIN);
    done_d    = state_d == S_DONE;
    rdlayer_d = issue_d ? layer_d : rdlayer_q;
    rdaddr_d  = issue_d ? addr_d  : rdaddr_q;
    iterout_d = issue_d ? iter_d  : iterout_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      layer_q   <= 1'b0;
      addr_q    <= '0;
      iter_q    <= '0;
      stop_q    <= 1'b0;
      gcnt_q    <= '0;
      dcnt_q    <= '0;
      rdlayer_q <= 1'b0;
      rdaddr_q  <= '0;
      iterout_q <= '0;
      rden_q    <= 1'b0;
      rdene_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      addr_q    <= addr_d;
      iter_q    <= iter_d;
      stop_q    <= stop_d;
      gcnt_q    <= gcnt_d;
      dcnt_q    <= dcnt_d;
      rdlayer_q <= rdlayer_d;
      rdaddr_q  <= rdaddr_d;
      iterout_q <= iterout_d;
      rden_q    <= rden_d;
      rdene_q   <= rdene_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rdlayer_regin   = rdlayer_q;
  assign rdaddress_regin = rdaddr_q;
  assign rden_LLR_regin  = rden_q;
  assign rden_E          = rdene_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign iter_count      = iterout_q;

endmodule
